// File: rtl/ysyx_220053_pkg.sv
// Shared constants for the ysyx_220053 decode stage:
// opcodes, immediate format codes and FSM states.
package ysyx_220053_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/ysyx_220053_imm_gen.sv
// Immediate generator: sign-extends the selected
// RV64I immediate format to XLEN bits.
module ysyx_220053_imm_gen
  import ysyx_220053_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      ext_op,
  output logic [XLEN-1:0] imm
);

  logic s;
  assign s = instr[31];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      ext_op == IMM_I:
        imm = {{(XLEN-12){s}}, instr[31:20]};
      ext_op == IMM_S:
        imm = {{(XLEN-12){s}}, instr[31:25],
               instr[11:7]};
      ext_op == IMM_B:
        imm = {{(XLEN-13){s}}, s, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      ext_op == IMM_U:
        imm = {{(XLEN-32){s}}, instr[31:12],
               12'b0};
      ext_op == IMM_J:
        imm = {{(XLEN-21){s}}, s, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_220053_idu_pipe.sv
// Buffered RV64I decode stage: FIFO between IFU and EXU,
// combinational decode of the head, halt on ebreak.
module ysyx_220053_idu_pipe
  import ysyx_220053_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      op,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      ext_op,
  output logic            wen,
  output logic            illegal,
  output logic            is_ebreak,
  output logic            trap_o,
  output logic            halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [0:0]      state;

  logic run;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [31:0] instr;

  assign run   = (state == ST_RUN);
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign in_ready  = !rst && run && !full && !flush_i;
  assign out_valid = run && !empty && !flush_i;
  assign halted    = (state == ST_HALT);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign instr = mem_instr[head];
  assign pc_o  = mem_pc[head];
  assign op    = instr[6:0];
  assign rd    = instr[11:7];
  assign func3 = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign func7 = instr[31:25];

  // Format and write-enable per opcode; SYSTEM
  // legality depends on the immediate, resolved below.
  logic wen_op;
  logic known;
  logic sys;

  always_comb begin
    ext_op = IMM_NONE;
    wen_op = 1'b0;
    known  = 1'b1;
    sys    = 1'b0;
    unique case (1'b1)
      op == OP_LUI,
      op == OP_AUIPC: begin
        ext_op = IMM_U;
        wen_op = 1'b1;
      end
      op == OP_JAL: begin
        ext_op = IMM_J;
        wen_op = 1'b1;
      end
      op == OP_JALR,
      op == OP_LOAD,
      op == OP_IMM,
      op == OP_IMM32: begin
        ext_op = IMM_I;
        wen_op = 1'b1;
      end
      op == OP_STORE:
        ext_op = IMM_S;
      op == OP_BRANCH:
        ext_op = IMM_B;
      op == OP_OP,
      op == OP_OP32: begin
        ext_op = IMM_NONE;
        wen_op = 1'b1;
      end
      op == OP_SYSTEM: begin
        ext_op = IMM_I;
        sys    = 1'b1;
      end
      default:
        known = 1'b0;
    endcase
  end

  ysyx_220053_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr  (instr[31:7]),
    .ext_op (ext_op),
    .imm    (imm)
  );

  logic ebreak_enc;
  assign ebreak_enc = sys && (func3 == 3'd0) &&
                      (imm == XLEN'(1));

  assign is_ebreak = ebreak_enc;
  assign illegal   = !known || (sys && !ebreak_enc);
  assign wen       = wen_op && known && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= instr_i;
      mem_pc[tail]    <= pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      trap_o <= 1'b0;
    end else begin
      trap_o <= 1'b0;
      if (run) begin
        if (pop && is_ebreak) begin
          state  <= ST_HALT;
          head   <= '0;
          tail   <= '0;
          count  <= '0;
          trap_o <= 1'b1;
        end else if (flush_i) begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end else begin
          if (push)
            tail <= tail + PW'(1);
          if (pop)
            head <= head + PW'(1);
          if (push && !pop)
            count <= count + CW'(1);
          else if (pop && !push)
            count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_idu_pipe.sv
// Directed bench for ysyx_220053_idu_pipe with
// hand-computed expectations.
module tb_ysyx_220053_idu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic        flush_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc_o;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [63:0] imm;
  logic [2:0]  ext_op;
  logic        wen;
  logic        illegal;
  logic        is_ebreak;
  logic        trap_o;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_220053_idu_pipe #(
    .XLEN  (64),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_o      (pc_o),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .func3     (func3),
    .func7     (func7),
    .imm       (imm),
    .ext_op    (ext_op),
    .wen       (wen),
    .illegal   (illegal),
    .is_ebreak (is_ebreak),
    .trap_o    (trap_o),
    .halted    (halted)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i,
                       input logic [63:0] p);
    in_valid = 1'b1;
    instr_i  = i;
    pc_i     = p;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    instr_i = '0;
    pc_i = '0;
    flush_i = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_trap", trap_o, 0);
    chk("rst_halted", halted, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // addi x1,x0,5
    offer(32'h0050_0093, 64'h8000_0000);
    #1;
    chk("addi_no_early_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", rd, 1);
    chk("addi_imm", imm, 5);
    chk("addi_ext", ext_op, 0);
    chk("addi_wen", wen, 1);
    chk("addi_pc", pc_o, 64'h8000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("addi_popped", out_valid, 0);

    // sw then beq -4
    offer(32'h0020_A423, 64'h8000_0004);
    tick();
    offer(32'hFE00_0EE3, 64'h8000_0008);
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("sw_imm", imm, 8);
    chk("sw_ext", ext_op, 1);
    chk("sw_wen", wen, 0);
    chk("sw_rs2", rs2, 2);
    out_ready = 1'b1;
    tick();
    #1;
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_ext", ext_op, 2);
    chk("beq_wen", wen, 0);
    chk("beq_pc", pc_o, 64'h8000_0008);
    tick();
    out_ready = 1'b0;
    #1;
    chk("drained", out_valid, 0);

    // lui, nop(rd=0), illegal with push+pop overlap
    offer(32'h8000_02B7, 64'h8000_000C);
    tick();
    offer(32'h0000_0013, 64'h8000_0010);
    out_ready = 1'b1;
    #1;
    chk("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_ext", ext_op, 3);
    chk("lui_wen", wen, 1);
    chk("lui_in_ready", in_ready, 1);
    tick();
    offer(32'h0000_007F, 64'h8000_0014);
    #1;
    chk("nop_valid", out_valid, 1);
    chk("nop_wen", wen, 0);
    chk("nop_illegal", illegal, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ill_illegal", illegal, 1);
    chk("ill_ext", ext_op, 7);
    chk("ill_imm", imm, 0);
    chk("ill_wen", wen, 0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("ill_drained", out_valid, 0);

    // fill, then pop with simultaneous offer
    offer(32'h0010_0113, 64'h100);
    tick();
    offer(32'h0020_0193, 64'h104);
    tick();
    offer(32'h0030_0213, 64'h108);
    out_ready = 1'b1;
    #1;
    chk("nobypass_ready", in_ready, 0);
    chk("order_a", rd, 2);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("order_b", rd, 3);
    chk("order_b_pc", pc_o, 64'h104);
    chk("after_pop_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("c_not_taken", out_valid, 0);

    // flush with two buffered
    offer(32'h0010_0113, 64'h200);
    tick();
    offer(32'h0020_0193, 64'h204);
    tick();
    in_valid = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("post_flush_empty", out_valid, 0);
    chk("post_flush_ready", in_ready, 1);

    // ebreak then addi
    offer(32'h0010_0073, 64'h300);
    tick();
    offer(32'h0050_0093, 64'h304);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ebreak_flag", is_ebreak, 1);
    chk("ebreak_illegal", illegal, 0);
    chk("ebreak_wen", wen, 0);
    chk("pre_trap", trap_o, 0);
    out_ready = 1'b1;
    tick();
    #1;
    chk("trap_pulse", trap_o, 1);
    chk("halted_now", halted, 1);
    chk("halt_valid", out_valid, 0);
    chk("halt_ready", in_ready, 0);
    flush_i = 1'b1;
    offer(32'h0050_0093, 64'h308);
    tick();
    #1;
    chk("trap_once", trap_o, 0);
    chk("halted_stays", halted, 1);
    chk("halt_valid2", out_valid, 0);
    chk("halt_ready2", in_ready, 0);
    flush_i = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    rst = 1'b1;
    #1;
    chk("rst_mid_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rerun_halted", halted, 0);
    chk("rerun_valid", out_valid, 0);
    chk("rerun_ready", in_ready, 1);
    offer(32'h0070_0393, 64'h400);
    tick();
    in_valid = 1'b0;
    #1;
    chk("rerun_rd", rd, 7);
    chk("rerun_imm", imm, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
